// File: rtl/sdram_port_sram_if.sv
// User-port bundle of the SDRAM controller, shared by the requester and the RAM-backed responder.
// proto_err exists only when SDRAM_PORT_SRAM_PROTO_CHK_EN is defined.
interface sdram_port_sram_if;
  logic        sdram_wr_req;
  logic        sdram_wr_ack;
  logic [23:0] sdram_wr_addr;
  logic [9:0]  sdram_wr_burst;
  logic [15:0] sdram_din;
  logic        sdram_rd_req;
  logic        sdram_rd_ack;
  logic [23:0] sdram_rd_addr;
  logic [9:0]  sdram_rd_burst;
  logic [15:0] sdram_dout;
  logic        sdram_init_done;
`ifdef SDRAM_PORT_SRAM_PROTO_CHK_EN
  logic        proto_err;

  modport master (
    output sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
    output sdram_rd_req, sdram_rd_addr, sdram_rd_burst,
    input  sdram_wr_ack, sdram_rd_ack, sdram_dout, sdram_init_done, proto_err
  );
  modport slave (
    input  sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
    input  sdram_rd_req, sdram_rd_addr, sdram_rd_burst,
    output sdram_wr_ack, sdram_rd_ack, sdram_dout, sdram_init_done, proto_err
  );
`else
  modport master (
    output sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
    output sdram_rd_req, sdram_rd_addr, sdram_rd_burst,
    input  sdram_wr_ack, sdram_rd_ack, sdram_dout, sdram_init_done
  );
  modport slave (
    input  sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
    input  sdram_rd_req, sdram_rd_addr, sdram_rd_burst,
    output sdram_wr_ack, sdram_rd_ack, sdram_dout, sdram_init_done
  );
`endif
endinterface

// File: rtl/sdram_port_sram.sv
// RAM-backed stand-in for the SDRAM controller user port: init delay, burst writes/reads, one-cycle gap.
// Optional protocol checker enabled by defining SDRAM_PORT_SRAM_PROTO_CHK_EN.
module sdram_port_sram #(
  parameter int ADDR_W      = 12,
  parameter int INIT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst_n,
  sdram_port_sram_if.slave bus
);
  localparam int CNT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {INIT, IDLE, WRITE, RD_PRE, READ, GAP} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  init_cnt_q;
  logic              init_done_q;
  logic              wr_ack_q;
  logic              rd_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [9:0]        left_q;
  logic [15:0]       dout_q;
  logic [15:0]       mem [2**ADDR_W];
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.sdram_wr_addr[23:ADDR_W], bus.sdram_rd_addr[23:ADDR_W]};

  // Natural ADDR_W-bit overflow gives the in-burst wrap.
  assign addr_d = addr_q + 1'b1;

  // The state register is cleared asynchronously, so a reset mid-burst stops writes at once.
  always_ff @(posedge clk) begin
    if (state_q == WRITE) mem[addr_q] <= bus.sdram_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      dout_q      <= '0;
      addr_q      <= '0;
      left_q      <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (init_cnt_q == CNT_LAST) begin
            init_done_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (bus.sdram_wr_req) begin
            addr_q   <= bus.sdram_wr_addr[ADDR_W-1:0];
            left_q   <= (bus.sdram_wr_burst == 10'd0) ? 10'd1 : bus.sdram_wr_burst;
            wr_ack_q <= 1'b1;
            state_q  <= WRITE;
          end else if (bus.sdram_rd_req) begin
            addr_q  <= bus.sdram_rd_addr[ADDR_W-1:0];
            left_q  <= (bus.sdram_rd_burst == 10'd0) ? 10'd1 : bus.sdram_rd_burst;
            state_q <= RD_PRE;
          end
        end
        WRITE: begin
          addr_q <= addr_d;
          if (left_q == 10'd1) begin
            wr_ack_q <= 1'b0;
            state_q  <= GAP;
          end else begin
            left_q <= left_q - 10'd1;
          end
        end
        // Prefetch the first word so it is on dout in the first ack cycle.
        RD_PRE: begin
          dout_q   <= mem[addr_q];
          addr_q   <= addr_d;
          rd_ack_q <= 1'b1;
          state_q  <= READ;
        end
        READ: begin
          if (left_q == 10'd1) begin
            rd_ack_q <= 1'b0;
            state_q  <= GAP;
          end else begin
            left_q <= left_q - 10'd1;
            dout_q <= mem[addr_q];
            addr_q <= addr_d;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= INIT;
      endcase
    end
  end

  assign bus.sdram_wr_ack    = wr_ack_q;
  assign bus.sdram_rd_ack    = rd_ack_q;
  assign bus.sdram_dout      = dout_q;
  assign bus.sdram_init_done = init_done_q;

`ifdef SDRAM_PORT_SRAM_PROTO_CHK_EN
  logic proto_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else if ((state_q == WRITE && !bus.sdram_wr_req) ||
                 (state_q == READ  && !bus.sdram_rd_req) ||
                 ((bus.sdram_wr_req || bus.sdram_rd_req) && !init_done_q)) begin
      proto_err_q <= 1'b1;
    end
  end

  assign bus.proto_err = proto_err_q;
`endif
endmodule

// File: tb/tb_sdram_port_sram.sv
// Directed bench for sdram_port_sram: bursts are scheduled into a per-cycle expectation table
// that a single compare process checks against the DUT on every falling edge.
`timescale 1ns/1ps
module tb_sdram_port_sram;
  localparam int INIT_CYCLES = 16;
  localparam int DEPTH       = 4096;
  localparam int NCYC        = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sdram_port_sram_if bus();

  sdram_port_sram #(.ADDR_W(12), .INIT_CYCLES(INIT_CYCLES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  int          since     = 0;
  bit          cmp_en    = 1'b0;
  int          perr_cyc  = -1;
  bit          exp_wr   [NCYC];
  bit          exp_rd   [NCYC];
  bit          exp_dv   [NCYC];
  logic [15:0] exp_dout [NCYC];
  logic [15:0] mem_m    [DEPTH];
  logic [15:0] cur_dout = 16'h0;
  logic [15:0] wdata    [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Cycle k is the interval after the k-th rising edge; since counts edges seen out of reset.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    since <= rst_n ? since + 1 : 0;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit e_wr, e_rd, e_init, e_perr;
      if (!rst_n) begin
        e_wr = 0; e_rd = 0; e_init = 0; cur_dout = 16'h0; perr_cyc = -1;
      end else begin
        e_wr   = (cyc < NCYC) ? exp_wr[cyc] : 1'b0;
        e_rd   = (cyc < NCYC) ? exp_rd[cyc] : 1'b0;
        if (cyc < NCYC && exp_dv[cyc]) cur_dout = exp_dout[cyc];
        e_init = (since >= INIT_CYCLES);
      end
      e_perr = (perr_cyc >= 0) && (cyc >= perr_cyc);
      chk("wr_ack", {31'b0, bus.sdram_wr_ack}, {31'b0, e_wr});
      chk("rd_ack", {31'b0, bus.sdram_rd_ack}, {31'b0, e_rd});
      chk("init_done", {31'b0, bus.sdram_init_done}, {31'b0, e_init});
      chk("dout", {16'b0, bus.sdram_dout}, {16'b0, cur_dout});
`ifdef SDRAM_PORT_SRAM_PROTO_CHK_EN
      chk("proto_err", {31'b0, bus.proto_err}, {31'b0, e_perr});
`else
      if (e_perr && cyc < 0) chk("perr_unused", 32'd0, 32'd1);
`endif
    end
  end

  task automatic init_wait(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.sdram_init_done) begin
        n = i;
        break;
      end
    end
    chk(name, n, INIT_CYCLES);
  endtask

  // Write sampled at edge s: acks in cycles s..s+eff-1, GAP in s+eff.
  task automatic do_write(input logic [23:0] a, input int n, input bit keep, input int drop_at);
    int s, eff;
    @(negedge clk);
    bus.sdram_wr_req   = 1'b1;
    bus.sdram_wr_addr  = a;
    bus.sdram_wr_burst = 10'(n);
    s   = cyc + 1;
    eff = (n == 0) ? 1 : n;
    for (int i = 0; i < eff; i++) exp_wr[s+i] = 1'b1;
    for (int i = 0; i < eff; i++) begin
      @(negedge clk);
      bus.sdram_din = wdata[i];
      mem_m[(int'(a[11:0]) + i) % DEPTH] = wdata[i];
      if (i == drop_at) begin
        bus.sdram_wr_req = 1'b0;
        if (perr_cyc < 0) perr_cyc = s + i + 1;
      end
    end
    @(negedge clk);
    if (!keep) bus.sdram_wr_req = 1'b0;
  endtask

  // Read sampled at edge s: RD_PRE in s, acks in s+1..s+eff, GAP in s+eff+1.
  task automatic do_read(input logic [23:0] a, input int n);
    int s, eff;
    @(negedge clk);
    bus.sdram_rd_req   = 1'b1;
    bus.sdram_rd_addr  = a;
    bus.sdram_rd_burst = 10'(n);
    s   = cyc + 1;
    eff = (n == 0) ? 1 : n;
    for (int i = 0; i < eff; i++) begin
      exp_rd[s+1+i]   = 1'b1;
      exp_dv[s+1+i]   = 1'b1;
      exp_dout[s+1+i] = mem_m[(int'(a[11:0]) + i) % DEPTH];
    end
    repeat (eff + 2) @(negedge clk);
    bus.sdram_rd_req = 1'b0;
  endtask

  // Both requests rise together: 2-word write first, then the read follows after GAP and IDLE.
  task automatic do_both(input logic [23:0] a);
    int s;
    @(negedge clk);
    bus.sdram_wr_req = 1'b1; bus.sdram_wr_addr = a; bus.sdram_wr_burst = 10'd2;
    bus.sdram_rd_req = 1'b1; bus.sdram_rd_addr = a; bus.sdram_rd_burst = 10'd2;
    s = cyc + 1;
    exp_wr[s] = 1'b1; exp_wr[s+1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.sdram_din = wdata[i];
      mem_m[(int'(a[11:0]) + i) % DEPTH] = wdata[i];
    end
    for (int i = 0; i < 2; i++) begin
      exp_rd[s+5+i]   = 1'b1;
      exp_dv[s+5+i]   = 1'b1;
      exp_dout[s+5+i] = mem_m[(int'(a[11:0]) + i) % DEPTH];
    end
    @(negedge clk);
    bus.sdram_wr_req = 1'b0;
    repeat (5) @(negedge clk);
    bus.sdram_rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    bus.sdram_wr_req = 1'b0; bus.sdram_wr_addr = '0; bus.sdram_wr_burst = '0; bus.sdram_din = '0;
    bus.sdram_rd_req = 1'b0; bus.sdram_rd_addr = '0; bus.sdram_rd_burst = '0;
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    init_wait("init_latency");

    for (int i = 0; i < 4; i++) wdata[i] = 16'hA001 + 16'(i);
    do_write(24'h000010, 4, 1'b0, -1);
    do_read(24'h000010, 4);
    chk("dout_hold_a004", {16'b0, bus.sdram_dout}, 32'h0000A004);

    wdata[0] = 16'h1234; wdata[1] = 16'h5678;
    do_both(24'h000020);
    chk("both_last_dout", {16'b0, bus.sdram_dout}, 32'h00005678);

    for (int i = 0; i < 4; i++) wdata[i] = 16'(i + 1);
    do_write(24'h000FFE, 4, 1'b0, -1);
    chk("model_wrap_ffe", {16'b0, mem_m[12'hFFE]}, 32'd1);
    chk("model_wrap_000", {16'b0, mem_m[12'h000]}, 32'd3);
    do_read(24'h123FFE, 4);
    chk("dout_wrap_last", {16'b0, bus.sdram_dout}, 32'd4);
    do_read(24'h000000, 2);
    chk("dout_wrap_001", {16'b0, bus.sdram_dout}, 32'd4);

    wdata[0] = 16'h5555;
    do_write(24'h000050, 0, 1'b0, -1);
    do_read(24'h000050, 0);
    chk("burst0_dout", {16'b0, bus.sdram_dout}, 32'h00005555);

    for (int i = 0; i < 3; i++) wdata[i] = 16'h7000 + 16'(i);
    do_write(24'h000300, 3, 1'b1, -1);
    for (int i = 0; i < 3; i++) wdata[i] = 16'h7100 + 16'(i);
    do_write(24'h000303, 3, 1'b0, -1);
    do_read(24'h000300, 6);

    for (int i = 0; i < 4; i++) wdata[i] = 16'hD000 + 16'(i);
    do_write(24'h000200, 4, 1'b0, 1);
    do_read(24'h000200, 4);
`ifdef SDRAM_PORT_SRAM_PROTO_CHK_EN
    chk("perr_sticky", {31'b0, bus.proto_err}, 32'd1);
`endif

    for (int i = 0; i < 8; i++) wdata[i] = 16'hC000 + 16'(i);
    do_write(24'h000100, 8, 1'b0, -1);
    for (int i = 0; i < 8; i++) wdata[i] = 16'hB000 + 16'(i);
    @(negedge clk);
    bus.sdram_wr_req = 1'b1; bus.sdram_wr_addr = 24'h000100; bus.sdram_wr_burst = 10'd8;
    s = cyc + 1;
    for (int i = 0; i < 8; i++) exp_wr[s+i] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.sdram_din = wdata[i];
      mem_m[12'h100 + i] = wdata[i];
    end
    @(negedge clk);
    bus.sdram_din = wdata[2];
    #2;
    rst_n = 1'b0;
    bus.sdram_wr_req = 1'b0;
    for (int i = 3; i < 8; i++) exp_wr[s+i] = 1'b0;
    #1;
    chk("reset_ack_drop", {31'b0, bus.sdram_wr_ack}, 32'd0);
    chk("reset_init_clr", {31'b0, bus.sdram_init_done}, 32'd0);
    chk("reset_dout_clr", {16'b0, bus.sdram_dout}, 32'd0);
`ifdef SDRAM_PORT_SRAM_PROTO_CHK_EN
    chk("reset_perr_clr", {31'b0, bus.proto_err}, 32'd0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    init_wait("init_after_reset");
    do_read(24'h000100, 8);
    chk("model_abort_w1", {16'b0, mem_m[12'h101]}, 32'h0000B001);
    chk("model_abort_w2", {16'b0, mem_m[12'h102]}, 32'h0000C002);
    chk("dout_after_abort", {16'b0, bus.sdram_dout}, 32'h0000C007);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
